ahblite_slave_mux: RTL
======================

# ahblite_slave_mux

AHB-Lite data-phase response multiplexer with built-in default slave. Sits directly downstream of the address decoder on the single-master bus. Registers the decoder's six one-hot `Px_HSEL` lines in the address phase, then routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master in the data phase. Transfers that hit no enabled port are answered by an internal default slave.

## Interface
- `Port0_en` … `Port5_en`, default 1: port enable. A disabled port's HSEL is ignored and the port is treated as unmapped.
- `HCLK`  in  1  bus clock.
- `HRESETn`  in  1  reset: synchronous, active-low.
- `HREADY`  in  1  system HREADY. Fed back from this block's `HREADYOUT` at top level.
- `HTRANS`  in  2  master transfer type. Bit 1 high means NONSEQ/SEQ.
- `P0_HSEL` … `P5_HSEL`  in  1 each  decoder selects, address phase.
- `P0_HREADYOUT` … `P5_HREADYOUT`  in  1 each  slave ready.
- `P0_HRESP` … `P5_HRESP`  in  1 each  slave response: 0 = OKAY, 1 = ERROR.
- `P0_HRDATA` … `P5_HRDATA`  in  32 each  slave read data.
- `HREADYOUT`  out  1  muxed ready to master. Reset value 1.
- `HRESP`  out  1  muxed response. Reset value 0.
- `HRDATA`  out  32  muxed read data. Reset value 0.

## Operation
- **Enable masking.** Effective select is `sel_i = Px_HSEL & Px_en`.
- **Priority.** If more than one effective select is high, the lowest index wins. The result is one-hot `sel_a[5:0]`.
- **Address-phase register.** `sel_d[5:0]` is loaded from `sel_a` on the rising HCLK edge where `HREADY=1`. It holds while `HREADY=0`.
- **Data-phase mux, `sel_d` non-zero.** `HRDATA`, `HREADYOUT` and `HRESP` come combinationally from the selected port.
- **Data-phase mux, `sel_d` zero.** Outputs come from the default slave.
- **Default-slave FSM, state DS_IDLE.**
  - Outputs are HREADYOUT=1, HRESP=0.
  - Goes to DS_ERR1 on an edge with HREADY=1, `sel_a`=0 and HTRANS[1]=1.
- **State DS_ERR1.**
  - Outputs are HREADYOUT=0, HRESP=1.
  - Always goes to DS_ERR2 on the next edge.
- **State DS_ERR2.**
  - Outputs are HREADYOUT=1, HRESP=1.
  - On the next edge it re-evaluates the DS_IDLE condition: to DS_ERR1 if met, otherwise to DS_IDLE.
  - This completes the AHB two-cycle ERROR response.
- **Unmapped IDLE/BUSY.** An unmapped transfer with HTRANS[1]=0 gets a zero-wait OKAY and stays in DS_IDLE.
- **Read data.** `HRDATA` is 0 whenever `sel_d`=0.
- **Mid-transfer reset.** `HRESETn=0` sampled on any edge, including mid wait-state or DS_ERR1, forces `sel_d`=0 and DS_IDLE. Outputs return to their reset values on the following cycle.

## Timing
- The mux adds zero latency: slave response to master output is purely combinational from `sel_d`.
- There is one register stage on select only, which aligns it to the data phase.
- Slave wait states pass straight through. `sel_d` is frozen for their whole duration, so back-to-back transfers to different slaves switch ports exactly at the HREADY=1 edge.
- A default-slave ERROR always takes exactly 2 cycles: DS_ERR1, then DS_ERR2.
- A following transfer is only sampled at DS_ERR2's edge, the first edge with HREADY=1.
- While the default slave owns the data phase (`sel_d`=0), slave `HREADYOUT` inputs are ignored.

## Configuration
- The macro `AHBLITE_DEFAULT_SLAVE_ERR_EN` controls the ERROR response.
- **Defined.** The DS_ERR1/DS_ERR2 FSM is built. Active unmapped transfers get the two-cycle ERROR.
- **Undefined.**
  - The FSM is removed and the default slave is tied to HREADYOUT=1, HRESP=0.
  - Unmapped transfers of any HTRANS complete as zero-wait OKAY with HRDATA=0.

## Test plan
- **Basic read.** NONSEQ read with P1_HSEL=1, P1_HRDATA=0x12345678, P1_HREADYOUT=1.
  - Next cycle HRDATA=0x12345678, HRESP=0, HREADYOUT=1.
- **Wait states and port switch.** P3 is selected and holds P3_HREADYOUT=0 for 3 cycles. Meanwhile P0_HSEL is asserted for the next transfer.
  - HREADYOUT=0 for 3 cycles and HRDATA tracks P3 throughout.
  - The mux switches to P0 only after the P3 ready edge.
- **Unmapped active transfer.** NONSEQ with all HSEL=0 (e.g. HADDR 0x50000000).
  - Cycle 1: HREADYOUT=0, HRESP=1.
  - Cycle 2: HREADYOUT=1, HRESP=1.
  - Then IDLE gives HREADYOUT=1, HRESP=0.
- **Unmapped IDLE, and disabled port.**
  - HTRANS=IDLE with all HSEL=0 gives a zero-wait OKAY and HRDATA=0.
  - Repeat with Port4_en=0 and P4_HSEL=1: same result when IDLE; two-cycle ERROR when NONSEQ.
- **Overlap and reset.**
  - P2_HSEL and P5_HSEL high together: P2 data is returned.
  - Assert HRESETn=0 during DS_ERR1: the next cycle gives HREADYOUT=1, HRESP=0, HRDATA=0.
- **Build without the macro.** Compile without `AHBLITE_DEFAULT_SLAVE_ERR_EN` and issue an unmapped NONSEQ.
  - Zero-wait OKAY, HRDATA=0.

Source files
------------

// File: rtl/ahblite_slave_mux_if.sv
// AHB-Lite data-phase bus between the address decoder, six slaves and the
// response mux. The "slave" modport is the mux side; "master" is the fabric side.
interface ahblite_slave_mux_if;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic        P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL, P5_HSEL;
  logic        P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT;
  logic        P3_HREADYOUT, P4_HREADYOUT, P5_HREADYOUT;
  logic        P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP, P5_HRESP;
  logic [31:0] P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P4_HRDATA, P5_HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HREADY, HTRANS,
    input  P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL, P5_HSEL,
    input  P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT,
    input  P3_HREADYOUT, P4_HREADYOUT, P5_HREADYOUT,
    input  P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP, P5_HRESP,
    input  P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P4_HRDATA, P5_HRDATA,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HREADY, HTRANS,
    output P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL, P5_HSEL,
    output P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT,
    output P3_HREADYOUT, P4_HREADYOUT, P5_HREADYOUT,
    output P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP, P5_HRESP,
    output P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P4_HRDATA, P5_HRDATA,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite six-port data-phase response mux with built-in default slave.
// Define AHBLITE_DEFAULT_SLAVE_ERR_EN to answer unmapped active transfers with a two-cycle ERROR.
module ahblite_slave_mux #(
  parameter bit Port0_en = 1'b1,
  parameter bit Port1_en = 1'b1,
  parameter bit Port2_en = 1'b1,
  parameter bit Port3_en = 1'b1,
  parameter bit Port4_en = 1'b1,
  parameter bit Port5_en = 1'b1
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahblite_slave_mux_if.slave bus
);
  localparam int NUM_PORTS = 6;

  logic [NUM_PORTS-1:0]       en, hsel, pready, presp;
  logic [NUM_PORTS-1:0]       sel_i, sel_a, sel_d;
  logic [NUM_PORTS-1:0][31:0] prdata;
  logic                       ds_ready, ds_resp;
  logic                       mux_ready, mux_resp;
  logic [31:0]                mux_rdata;

  assign en     = {Port5_en, Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};
  assign hsel   = {bus.P5_HSEL, bus.P4_HSEL, bus.P3_HSEL,
                   bus.P2_HSEL, bus.P1_HSEL, bus.P0_HSEL};
  assign pready = {bus.P5_HREADYOUT, bus.P4_HREADYOUT, bus.P3_HREADYOUT,
                   bus.P2_HREADYOUT, bus.P1_HREADYOUT, bus.P0_HREADYOUT};
  assign presp  = {bus.P5_HRESP, bus.P4_HRESP, bus.P3_HRESP,
                   bus.P2_HRESP, bus.P1_HRESP, bus.P0_HRESP};
  assign prdata = {bus.P5_HRDATA, bus.P4_HRDATA, bus.P3_HRDATA,
                   bus.P2_HRDATA, bus.P1_HRDATA, bus.P0_HRDATA};

  // Isolate the lowest set bit: lowest enabled index wins on overlap.
  assign sel_i = hsel & en;
  assign sel_a = sel_i & (~sel_i + 6'd1);

  always_ff @(posedge HCLK) begin
    if (!HRESETn)        sel_d <= '0;
    else if (bus.HREADY) sel_d <= sel_a;
  end

`ifdef AHBLITE_DEFAULT_SLAVE_ERR_EN
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;
  ds_state_t ds_state, ds_next;
  logic      err_start;

  assign err_start = bus.HREADY && (sel_a == '0) && bus.HTRANS[1];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) ds_state <= DS_IDLE;
    else          ds_state <= ds_next;
  end

  always_comb begin
    ds_next  = ds_state;
    ds_ready = 1'b1;
    ds_resp  = 1'b0;
    case (ds_state)
      DS_IDLE: if (err_start) ds_next = DS_ERR1;
      DS_ERR1: begin
        ds_ready = 1'b0;
        ds_resp  = 1'b1;
        ds_next  = DS_ERR2;
      end
      DS_ERR2: begin
        ds_resp = 1'b1;
        ds_next = err_start ? DS_ERR1 : DS_IDLE;
      end
      default: ds_next = DS_IDLE;
    endcase
  end
`else
  assign ds_ready = 1'b1;
  assign ds_resp  = 1'b0;
`endif

  // sel_d is one-hot or zero, so an OR-reduction of the gated ports is the mux.
  always_comb begin
    mux_rdata = '0;
    mux_ready = 1'b0;
    mux_resp  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_d[i]) begin
        mux_rdata = mux_rdata | prdata[i];
        mux_ready = mux_ready | pready[i];
        mux_resp  = mux_resp  | presp[i];
      end
    end
  end

  assign bus.HRDATA    = (sel_d == '0) ? 32'h0    : mux_rdata;
  assign bus.HREADYOUT = (sel_d == '0) ? ds_ready : mux_ready;
  assign bus.HRESP     = (sel_d == '0) ? ds_resp  : mux_resp;

  logic unused_htrans;
  assign unused_htrans = ^bus.HTRANS;
endmodule
